// File: rtl/ucsbece154b_bp_perf_pkg.sv
// Shared definitions for the branch-predictor performance monitor: counter
// indices and the mispredict classification rule.
package ucsbece154b_bp_perf_pkg;

  localparam int CNT_CYCLES      = 0;
  localparam int CNT_RETIRED     = 1;
  localparam int CNT_BRANCHES    = 2;
  localparam int CNT_BR_MISPRED  = 3;
  localparam int CNT_JUMPS       = 4;
  localparam int CNT_JMP_MISPRED = 5;
  localparam int CNT_BTB_HIT     = 6;
  localparam int CNT_BTB_MISS    = 7;
  localparam int CNT_HIST_BASE   = 8;
  localparam int NUM_FIXED_CNT   = 8;

  // Jumps are always taken, so a jump is wrong unless predicted taken to the
  // right target; a branch target only matters when both sides say taken.
  function automatic logic is_mispredict(input logic is_jump,
                                         input logic pred_taken,
                                         input logic actual_taken,
                                         input logic target_eq);
    if (is_jump) return !pred_taken || !target_eq;
    return (pred_taken != actual_taken) || (pred_taken && actual_taken && !target_eq);
  endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating event counter with a sticky overflow flag. clr wipes value and
// flag; load0 restarts the count (window boundary) but keeps the flag.
module ucsbece154b_sat_counter import ucsbece154b_bp_perf_pkg::*; #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_i,
  input  logic                 clr_i,
  input  logic                 load0_i,
  output logic [CNT_WIDTH-1:0] value_o,
  output logic [CNT_WIDTH-1:0] next_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] value_q, value_d;
  logic                 ovf_q, ovf_d;
  logic                 at_max;

  assign at_max = &value_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    if (inc_i) begin
      if (at_max) ovf_d = 1'b1;
      else        value_d = value_q + 1'b1;
    end
    next_o = value_d;
    if (load0_i) value_d = '0;
    if (clr_i) begin
      value_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/ucsbece154b_bp_perf_monitor.sv
// Branch-predictor performance monitor: saturating event counters resolved in
// Execute, windowed snapshot bank, and a registered read port over both banks.
module ucsbece154b_bp_perf_monitor import ucsbece154b_bp_perf_pkg::*; #(
  parameter int CNT_WIDTH        = 32,
  parameter int NUM_HIST_BUCKETS = 8,
  parameter int WINDOW_LOG2      = 10,
  parameter int PC_WIDTH         = 32,
  localparam int NUM_CNT         = NUM_FIXED_CNT + NUM_HIST_BUCKETS,
  localparam int SEL_W           = $clog2(NUM_CNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 window_mode_i,
  input  logic                 retire_i,
  input  logic                 resolve_valid_i,
  input  logic                 resolve_is_branch_i,
  input  logic                 resolve_is_jump_i,
  input  logic                 pred_taken_i,
  input  logic                 actual_taken_i,
  input  logic [PC_WIDTH-1:0]  pred_target_i,
  input  logic [PC_WIDTH-1:0]  actual_target_i,
  input  logic                 btb_hit_i,
  input  logic [PC_WIDTH-1:0]  resolve_pc_i,
  input  logic                 read_snap_i,
  input  logic [SEL_W-1:0]     read_sel_i,
  output logic [CNT_WIDTH-1:0] read_data_o,
  output logic [NUM_CNT-1:0]   overflow_o,
  output logic                 window_done_o,
  output logic                 proto_err_o
);

  localparam int HIST_W = $clog2(NUM_HIST_BUCKETS);

  logic [NUM_CNT-1:0]   inc;
  logic [CNT_WIDTH-1:0] live      [NUM_CNT];
  logic [CNT_WIDTH-1:0] live_next [NUM_CNT];
  logic [CNT_WIDTH-1:0] snap_q    [NUM_CNT];
  logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] read_data_q, read_data_d;
  logic                 window_done_q, proto_err_q, proto_err_d;
  logic                 jmp_ev, br_ev, mispred, target_eq, capture;
  logic [HIST_W-1:0]    bucket;
  logic                 unused_pc_bits;

  // A jump wins when both type flags are set; that combination is a protocol error.
  assign jmp_ev    = resolve_valid_i && resolve_is_jump_i;
  assign br_ev     = resolve_valid_i && resolve_is_branch_i && !resolve_is_jump_i;
  assign target_eq = (pred_target_i == actual_target_i);
  assign mispred   = (jmp_ev || br_ev) &&
                     is_mispredict(jmp_ev, pred_taken_i, actual_taken_i, target_eq);
  assign bucket    = resolve_pc_i[2 +: HIST_W];
  assign unused_pc_bits = ^resolve_pc_i;

  always_comb begin
    inc                  = '0;
    inc[CNT_CYCLES]      = 1'b1;
    inc[CNT_RETIRED]     = retire_i;
    inc[CNT_BRANCHES]    = br_ev;
    inc[CNT_BR_MISPRED]  = br_ev && mispred;
    inc[CNT_JUMPS]       = jmp_ev;
    inc[CNT_JMP_MISPRED] = jmp_ev && mispred;
    inc[CNT_BTB_HIT]     = (br_ev || jmp_ev) && btb_hit_i;
    inc[CNT_BTB_MISS]    = (br_ev || jmp_ev) && !btb_hit_i;
    for (int b = 0; b < NUM_HIST_BUCKETS; b++)
      inc[CNT_HIST_BASE + b] = mispred && (bucket == HIST_W'(b));
    if (!enable_i) inc = '0;
  end

  // The last enabled cycle of a window closes it unless a clear overrides.
  assign capture = enable_i && window_mode_i && !clear_i && (&wcnt_q);

  always_comb begin
    wcnt_d = wcnt_q;
    if (clear_i || !window_mode_i) wcnt_d = '0;
    else if (enable_i)             wcnt_d = wcnt_q + 1'b1;  // wraps to 0 on capture
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    ucsbece154b_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (inc[i]),
      .clr_i   (clear_i),
      .load0_i (capture),
      .value_o (live[i]),
      .next_o  (live_next[i]),
      .ovf_o   (overflow_o[i])
    );
  end

  always_comb begin
    read_data_d = '0;
    if ({1'b0, read_sel_i} < (SEL_W+1)'(NUM_CNT))
      read_data_d = read_snap_i ? snap_q[read_sel_i] : live[read_sel_i];
  end

  assign proto_err_d = proto_err_q ||
                       (enable_i && resolve_valid_i && resolve_is_branch_i && resolve_is_jump_i);

  // NOTE: the snapshot bank is reset explicitly because software may read it
  // before the first window has closed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= '0;
      wcnt_q        <= '0;
      read_data_q   <= '0;
      window_done_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      if (capture)
        for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= live_next[i];
      wcnt_q        <= wcnt_d;
      read_data_q   <= read_data_d;
      window_done_q <= capture;
      proto_err_q   <= proto_err_d;
    end
  end

  assign read_data_o   = read_data_q;
  assign window_done_o = window_done_q;
  assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_ucsbece154b_bp_perf_monitor.sv
// Directed bench for the BP performance monitor: a 32-bit instance and a
// 4-bit instance (both with 16-cycle windows) share one stimulus stream.
module tb_ucsbece154b_bp_perf_monitor;

  logic clk = 1'b0;
  logic reset, enable, clear, wmode, retire, rv, is_br, is_jmp, pt, at, btb;
  logic [31:0] ptgt, atgt, pc;
  logic        rsnap;
  logic [3:0]  rsel;

  logic [31:0] rd_w;
  logic [15:0] ovf_w;
  logic        done_w, perr_w;
  logic [3:0]  rd_n;
  logic [15:0] ovf_n;
  logic        done_n, perr_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ucsbece154b_bp_perf_monitor #(.CNT_WIDTH(32), .NUM_HIST_BUCKETS(8), .WINDOW_LOG2(4), .PC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .enable_i(enable), .clear_i(clear), .window_mode_i(wmode),
    .retire_i(retire), .resolve_valid_i(rv), .resolve_is_branch_i(is_br), .resolve_is_jump_i(is_jmp),
    .pred_taken_i(pt), .actual_taken_i(at), .pred_target_i(ptgt), .actual_target_i(atgt),
    .btb_hit_i(btb), .resolve_pc_i(pc), .read_snap_i(rsnap), .read_sel_i(rsel),
    .read_data_o(rd_w), .overflow_o(ovf_w), .window_done_o(done_w), .proto_err_o(perr_w)
  );

  ucsbece154b_bp_perf_monitor #(.CNT_WIDTH(4), .NUM_HIST_BUCKETS(8), .WINDOW_LOG2(4), .PC_WIDTH(32)) dut_n (
    .clk(clk), .reset(reset), .enable_i(enable), .clear_i(clear), .window_mode_i(wmode),
    .retire_i(retire), .resolve_valid_i(rv), .resolve_is_branch_i(is_br), .resolve_is_jump_i(is_jmp),
    .pred_taken_i(pt), .actual_taken_i(at), .pred_target_i(ptgt), .actual_target_i(atgt),
    .btb_hit_i(btb), .resolve_pc_i(pc), .read_snap_i(rsnap), .read_sel_i(rsel),
    .read_data_o(rd_n), .overflow_o(ovf_n), .window_done_o(done_n), .proto_err_o(perr_n)
  );

  // Inputs change just after a falling edge; outputs are sampled there too.
  task automatic rd(input logic snap, input logic [3:0] sel);
    rsnap = snap;
    rsel  = sel;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; wmode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_w !== 32'd0 || ovf_w !== 16'd0 || done_w !== 1'b0 || perr_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%0h ovf=%0h done=%0b perr=%0b exp all 0", rd_w, ovf_w, done_w, perr_w);
    end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    rd(1'b0, 4'd0);
    checks++;
    if (rd_w !== 32'd20) begin
      errors++; $display("FAIL cycles_live got %0d exp 20", rd_w);
    end
    checks++;
    if (rd_n !== 4'd15 || ovf_n[0] !== 1'b1) begin
      errors++; $display("FAIL cycles_narrow_sat got %0d ovf=%0b exp 15 ovf=1", rd_n, ovf_n[0]);
    end
    for (int s = 1; s < 16; s++) begin
      rd(1'b0, 4'(s));
      checks++;
      if (rd_w !== 32'd0) begin
        errors++; $display("FAIL idle_counter_%0d got %0d exp 0", s, rd_w);
      end
    end
    checks++;
    if (ovf_w !== 16'd0) begin
      errors++; $display("FAIL ovf_wide_idle got %0h exp 0", ovf_w);
    end
  endtask

  task automatic test_branches();
    int sels [8] = '{2, 3, 4, 5, 6, 7, 8, 11};
    int exps [8] = '{6, 1, 0, 0, 6, 0, 0, 1};
    do_clear();
    enable = 1'b1; rv = 1'b1; is_br = 1'b1; is_jmp = 1'b0;
    pt = 1'b1; at = 1'b1; ptgt = 32'h100; atgt = 32'h100; btb = 1'b1; pc = 32'h2C;
    repeat (5) @(negedge clk);
    pt = 1'b0;
    @(negedge clk);
    rv = 1'b0; is_br = 1'b0; enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd(1'b0, 4'(sels[k]));
      checks++;
      if (rd_w !== 32'(exps[k])) begin
        errors++; $display("FAIL branch_cnt_%0d got %0d exp %0d", sels[k], rd_w, exps[k]);
      end
    end
  endtask

  task automatic test_jumps();
    int sels [7] = '{2, 3, 4, 5, 6, 7, 12};
    int exps [7] = '{0, 0, 2, 1, 0, 2, 1};
    do_clear();
    enable = 1'b1; rv = 1'b1; is_jmp = 1'b1; is_br = 1'b0;
    pt = 1'b1; at = 1'b1; ptgt = 32'h48; atgt = 32'h4C; btb = 1'b0; pc = 32'h10;
    @(negedge clk);
    checks++;
    if (perr_w !== 1'b0) begin
      errors++; $display("FAIL proto_err_early got %0b exp 0", perr_w);
    end
    is_br = 1'b1; ptgt = 32'h4C;
    @(negedge clk);
    rv = 1'b0; is_br = 1'b0; is_jmp = 1'b0; enable = 1'b0;
    checks++;
    if (perr_w !== 1'b1) begin
      errors++; $display("FAIL proto_err_set got %0b exp 1", perr_w);
    end
    for (int k = 0; k < 7; k++) begin
      rd(1'b0, 4'(sels[k]));
      checks++;
      if (rd_w !== 32'(exps[k])) begin
        errors++; $display("FAIL jump_cnt_%0d got %0d exp %0d", sels[k], rd_w, exps[k]);
      end
    end
    do_clear();
    checks++;
    if (perr_w !== 1'b1) begin
      errors++; $display("FAIL proto_err_after_clear got %0b exp 1", perr_w);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (perr_w !== 1'b0) begin
      errors++; $display("FAIL proto_err_after_reset got %0b exp 0", perr_w);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    enable = 1'b1; retire = 1'b1;
    repeat (15) @(negedge clk);
    enable = 1'b0; retire = 1'b0;
    rd(1'b0, 4'd1);
    checks++;
    if (rd_n !== 4'd15 || ovf_n[1] !== 1'b0) begin
      errors++; $display("FAIL sat_at_max got %0d ovf=%0b exp 15 ovf=0", rd_n, ovf_n[1]);
    end
    enable = 1'b1; retire = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0; retire = 1'b0;
    rd(1'b0, 4'd1);
    checks++;
    if (rd_n !== 4'd15 || ovf_n[1] !== 1'b1) begin
      errors++; $display("FAIL sat_overflow got %0d ovf=%0b exp 15 ovf=1", rd_n, ovf_n[1]);
    end
    checks++;
    if (rd_w !== 32'd17 || ovf_w[1] !== 1'b0) begin
      errors++; $display("FAIL retire_wide got %0d ovf=%0b exp 17 ovf=0", rd_w, ovf_w[1]);
    end
    do_clear();
    rd(1'b0, 4'd1);
    checks++;
    if (rd_n !== 4'd0 || ovf_n !== 16'd0) begin
      errors++; $display("FAIL sat_clear got %0d ovf=%0h exp 0 ovf=0", rd_n, ovf_n);
    end
  endtask

  task automatic test_window();
    do_clear();
    wmode = 1'b1; enable = 1'b1; retire = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if (done_w !== ((i == 16) || (i == 32))) begin
        errors++; $display("FAIL window_done_cycle_%0d got %0b exp %0b", i, done_w, (i == 16) || (i == 32));
      end
    end
    wmode = 1'b0; enable = 1'b0; retire = 1'b0;
    rd(1'b1, 4'd1);
    checks++;
    if (rd_w !== 32'd16) begin
      errors++; $display("FAIL snap_retired got %0d exp 16", rd_w);
    end
    rd(1'b1, 4'd0);
    checks++;
    if (rd_w !== 32'd16) begin
      errors++; $display("FAIL snap_cycles got %0d exp 16", rd_w);
    end
    rd(1'b0, 4'd1);
    checks++;
    if (rd_w !== 32'd8) begin
      errors++; $display("FAIL live_retired_after_window got %0d exp 8", rd_w);
    end
  endtask

  task automatic test_clear_capture();
    wmode = 1'b1; enable = 1'b1; retire = 1'b0;
    repeat (15) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; enable = 1'b0;
    checks++;
    if (done_w !== 1'b0) begin
      errors++; $display("FAIL clear_suppress_pulse got %0b exp 0", done_w);
    end
    rd(1'b1, 4'd1);
    checks++;
    if (rd_w !== 32'd16) begin
      errors++; $display("FAIL clear_keeps_snap got %0d exp 16", rd_w);
    end
    rd(1'b0, 4'd0);
    checks++;
    if (rd_w !== 32'd0) begin
      errors++; $display("FAIL clear_live_cycles got %0d exp 0", rd_w);
    end
    enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (done_w !== (i == 16)) begin
        errors++; $display("FAIL wcnt_restart_cycle_%0d got %0b exp %0b", i, done_w, i == 16);
      end
    end
    enable = 1'b0; wmode = 1'b0;
    rd(1'b1, 4'd1);
    checks++;
    if (rd_w !== 32'd0) begin
      errors++; $display("FAIL snap_after_restart got %0d exp 0", rd_w);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; wmode = 1'b0; retire = 1'b0;
    rv = 1'b0; is_br = 1'b0; is_jmp = 1'b0; pt = 1'b0; at = 1'b0; btb = 1'b0;
    ptgt = '0; atgt = '0; pc = '0; rsnap = 1'b0; rsel = '0;
    @(negedge clk);
    test_reset();
    test_branches();
    test_jumps();
    test_saturation();
    test_window();
    test_clear_capture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_bp_perf_monitor.md
Name: ucsbece154b_bp_perf_monitor

Overview:
Synthesizable branch-predictor performance monitor that sits beside the RISC-V pipeline and replaces bench-only statistics with hardware counters. It counts the following events at Execute-stage resolution:
- cycles and retired instructions
- branches and branch mispredicts
- jumps and jump mispredicts
- BTB hits and misses
- a per-PC-bucket mispredict histogram

Counters saturate and are sampled over fixed windows into a snapshot bank. Either the live bank or the snapshot bank can be read back with a registered read port.

Parameters:
CNT_WIDTH, 32, width of every event counter
NUM_HIST_BUCKETS, 8, mispredict histogram buckets (power of 2, >=2)
WINDOW_LOG2, 10, sample window length = 2^WINDOW_LOG2 enabled cycles
PC_WIDTH, 32, width of resolved PC

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
enable_i  in  1  counting enable; when low, all live state holds
clear_i  in  1  synchronous clear of live counters, window counter and overflow flags
window_mode_i  in  1  1 = windowed sampling active
retire_i  in  1  instruction retired this cycle (RegWrite in W)
resolve_valid_i  in  1  control-flow instruction resolved in E this cycle
resolve_is_branch_i  in  1  resolved instruction is a conditional branch
resolve_is_jump_i  in  1  resolved instruction is JAL/JALR
pred_taken_i  in  1  prediction carried from F
actual_taken_i  in  1  PCSrcE outcome
pred_target_i  in  PC_WIDTH  BTB target carried from F
actual_target_i  in  PC_WIDTH  computed target in E
btb_hit_i  in  1  BTB tag hit recorded at F for this instruction
resolve_pc_i  in  PC_WIDTH  PC of resolved instruction
read_snap_i  in  1  1 = read snapshot bank, 0 = read live bank
read_sel_i  in  SEL_W  counter index, SEL_W = clog2(8+NUM_HIST_BUCKETS)
read_data_o  out  CNT_WIDTH  registered read data
overflow_o  out  8+NUM_HIST_BUCKETS  sticky per-counter saturation flags (live bank)
window_done_o  out  1  one-cycle pulse on snapshot capture
proto_err_o  out  1  sticky: is_branch and is_jump both asserted with resolve_valid_i

Behaviour:
- Reset (reset==0 at posedge): all live counters, snapshots, window counter, read_data_o, overflow_o, window_done_o and proto_err_o go to 0.
- Counter indices:
  - 0 cycles, 1 retired, 2 branches, 3 br_mispred, 4 jumps, 5 jmp_mispred, 6 btb_hit, 7 btb_miss
  - 8..8+B-1 histogram buckets
- Increments occur only when enable_i==1. Each counter increments by at most 1 per cycle.
- Cycle counter increments every enabled cycle. Retired counter increments when retire_i==1.
- On resolve_valid_i:
  - if is_jump: count jump, even if is_branch is also set (set proto_err_o in that case)
  - else if is_branch: count branch
  - else: nothing
- Mispredict rules:
  - branch mispredict = pred_taken!=actual_taken OR (both taken AND pred_target!=actual_target)
  - jump mispredict = !pred_taken OR pred_target!=actual_target
- BTB: on any counted branch or jump, btb_hit_i selects the hit counter or the miss counter.
- Histogram: on any mispredict, increment bucket resolve_pc_i[2+clog2(B)-1:2].
- Saturation: a counter at all-ones stays at all-ones. Its overflow_o bit sets on an attempted increment at all-ones and is cleared only by reset or clear_i.
- Window:
  - wcnt increments each enabled cycle while window_mode_i==1.
  - When wcnt==2^WINDOW_LOG2-1 and the cycle is enabled, at that edge:
    - snapshot <= live value including this cycle's increments
    - live counters <= 0
    - wcnt <= 0
    - window_done_o = 1 the next cycle for exactly one cycle
  - Overflow flags persist across the window boundary.
  - When window_mode_i==0, wcnt holds at 0 and the snapshot bank holds.
- Priority: reset > clear_i > window capture > increment. clear_i in the capture cycle suppresses the capture (no snapshot update, no pulse). clear_i does not touch snapshots.
- Read: read_data_o <= bank[read_sel_i] one cycle after the sample. An out-of-range read_sel_i returns 0. A read of the live bank returns the pre-edge value (the value before that cycle's increment).
- Reset asserted mid-window discards the partial window.

Decomposition:
- Package ucsbece154b_bp_perf_pkg holds:
  - counter index localparams (CNT_CYCLES..CNT_BTB_MISS, CNT_HIST_BASE=8)
  - NUM_FIXED_CNT=8
  - mispredict-classification function
- One sub-module: ucsbece154b_sat_counter, parameterised on CNT_WIDTH, with inputs inc, clr, load0 and outputs value, ovf. It is instantiated 8+B times.

Test Plan:
1. Hold reset low 3 cycles, then release with enable=1, window_mode=0, no events for 20 cycles -> live[0]=20, all other counters 0, read_data_o at read_sel=0 returns 20 one cycle after sample.
2. Five branches at PC 0x2C:
   - stimulus: pred_taken=1, actual_taken=1, targets equal, btb_hit=1; then one branch at PC 0x2C with pred_taken=0, actual_taken=1
   - required: branches=6, br_mispred=1, btb_hit=6, bucket 3 (0x2C[4:2]) = 1
3. JALR with pred_taken=1, pred_target=0x48, actual_target=0x4C, plus one cycle with both is_branch and is_jump set -> jumps=2, jmp_mispred>=1, proto_err_o=1 and stays 1 until reset.
4. CNT_WIDTH=4, 17 retire pulses -> live[1]=15, overflow_o[1]=1; clear_i -> live[1]=0, overflow_o[1]=0.
5. WINDOW_LOG2=4, window_mode=1, retire every cycle for 40 cycles -> window_done_o pulses at cycles 16 and 32; snapshot[1]=16; live[1]=8 after 40.
6. clear_i asserted in the capture cycle -> no window_done_o pulse, snapshot bank unchanged, live and wcnt = 0.
